// File: rtl/fp8_pkg.sv
// ---------------------------------------------------------------------------
// fp8_pkg
//   Shared definitions for the 8-bit minifloat adder sequencer.
//   The format has a 3-bit exponent and a 4-bit fraction whose MSB is an
//   explicit integer bit, so no hidden bit is ever inserted.
//   Contents:
//     EXP_W / FRAC_W - field widths
//     EXP_MAX        - largest exponent; results saturate to it
//     state_t        - sequencer states
//     fp8_t          - packed operand {exp, fract}
// ---------------------------------------------------------------------------
package fp8_pkg;

  localparam int EXP_W  = 3;
  localparam int FRAC_W = 4;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMP,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] fract;
  } fp8_t;

endpackage

// File: rtl/fp_mag_cmp.sv
// ---------------------------------------------------------------------------
// fp_mag_cmp
//   Combinational magnitude compare of two minifloat operands.
//   Ports:
//     a, b     in  operands (fp8_t)
//     swap     out 1 when b is strictly bigger than a. A full tie keeps a
//                  as the bigger operand.
//     exp_diff out unsigned exponent difference |a.exp - b.exp|
// ---------------------------------------------------------------------------
module fp_mag_cmp
  import fp8_pkg::*;
(
  input  fp8_t             a,
  input  fp8_t             b,
  output logic             swap,
  output logic [EXP_W-1:0] exp_diff
);

  // The exponent decides first. The fraction decides only when the
  // exponents are equal.
  assign swap = (b.exp > a.exp) ||
                ((b.exp == a.exp) && (b.fract > a.fract));

  assign exp_diff = swap ? (b.exp - a.exp) : (a.exp - b.exp);

endmodule

// File: rtl/fp8_add_seq.sv
// ---------------------------------------------------------------------------
// fp8_add_seq
//   Multi-cycle minifloat adder. It accepts an operand pair over a
//   valid/ready handshake. It then runs these steps in order:
//     compare/swap, alignment (one bit per cycle, at most FRAC_W shifts),
//     add, normalisation (one action per cycle).
//   The sum is held on a valid/ready output handshake.
//
//   Optional feature, macro FP8_ADD_SEQ_ROUND_EN:
//     When defined, alignment keeps a guard bit and a sticky bit, and the
//     add rounds to nearest even. When undefined, shifted-out bits are
//     truncated.
//
//   Ports:
//     clk, rst_n        clock (rising edge) and async active-low reset
//     in_valid/in_ready operand handshake. in_ready is high only in IDLE.
//     exp_a, fract_a    operand A
//     exp_b, fract_b    operand B
//     out_valid/ready   result handshake. out_valid is high only in DONE.
//     exp_res,fract_res result, held stable while out_ready is low
//     ovf               exponent saturated on this result
//     busy              state is not IDLE
//
//   The parameters must match the widths in fp8_pkg, because fp8_t and
//   fp_mag_cmp are built on the package widths.
// ---------------------------------------------------------------------------
module fp8_add_seq #(
  parameter int EXP_W  = fp8_pkg::EXP_W,
  parameter int FRAC_W = fp8_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  exp_a,
  input  logic [FRAC_W-1:0] fract_a,
  input  logic [EXP_W-1:0]  exp_b,
  input  logic [FRAC_W-1:0] fract_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  exp_res,
  output logic [FRAC_W-1:0] fract_res,
  output logic              ovf,
  output logic              busy
);

  import fp8_pkg::*;

  localparam int CNT_W = $clog2(FRAC_W + 1);

  state_t state, state_next;

  fp8_t              op_a, op_b;
  logic [EXP_W-1:0]  big_exp;     // working exponent, and the result exponent
  logic [FRAC_W-1:0] big_fract;
  logic [FRAC_W-1:0] small_fract;
  logic [EXP_W-1:0]  d;           // alignment shifts still owed
  logic [CNT_W-1:0]  shift_cnt;   // alignment shifts already done
  logic [FRAC_W:0]   acc;         // sum with carry bit; low bits are the result
  logic              ovf_q;

`ifdef FP8_ADD_SEQ_ROUND_EN
  logic guard, sticky;
  logic rnd;
`endif

  logic              cmp_swap;
  logic [EXP_W-1:0]  cmp_diff;
  logic [FRAC_W:0]   sum_raw, sum_w;
  logic              add_to_norm, align_last, norm_left_last, align_capped;

  fp_mag_cmp u_cmp (
    .a        (op_a),
    .b        (op_b),
    .swap     (cmp_swap),
    .exp_diff (cmp_diff)
  );

  // NOTE: every signal driven here gets a default before any branch, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    sum_raw = {1'b0, big_fract} + {1'b0, small_fract};
`ifdef FP8_ADD_SEQ_ROUND_EN
    rnd   = guard & (sticky | sum_raw[0]);
    sum_w = sum_raw + {{FRAC_W{1'b0}}, rnd};
`else
    sum_w = sum_raw;
`endif
    // Normalise on a carry. Also normalise when a non-zero sum lost its MSB
    // and the exponent still has room to move down. A zero sum passes
    // straight through.
    add_to_norm = sum_w[FRAC_W] |
                  ((sum_w != '0) & ~sum_w[FRAC_W-1] & (big_exp != '0));
    align_capped = (shift_cnt == CNT_W'(FRAC_W - 1));
    align_last   = (d == EXP_W'(1)) || align_capped;
    // Stop the left shift once the next shift brings a 1 into the MSB, or
    // once the exponent reaches 0.
    norm_left_last = acc[FRAC_W-2] || (big_exp == EXP_W'(1));
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (in_valid) state_next = S_CMP;
      S_CMP:   state_next = (cmp_diff != '0) ? S_ALIGN : S_ADD;
      S_ALIGN: if (align_last) state_next = S_ADD;
      S_ADD:   state_next = add_to_norm ? S_NORM : S_DONE;
      S_NORM:  if (acc[FRAC_W] || norm_left_last) state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All
  // registers read their old values at the edge, whatever the statement
  // order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a        <= '0;
      op_b        <= '0;
      big_exp     <= '0;
      big_fract   <= '0;
      small_fract <= '0;
      d           <= '0;
      shift_cnt   <= '0;
      acc         <= '0;
      ovf_q       <= 1'b0;
`ifdef FP8_ADD_SEQ_ROUND_EN
      guard       <= 1'b0;
      sticky      <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_a  <= '{exp: exp_a, fract: fract_a};
            op_b  <= '{exp: exp_b, fract: fract_b};
            ovf_q <= 1'b0;
          end
        end
        S_CMP: begin
          if (cmp_swap) begin
            big_exp     <= op_b.exp;
            big_fract   <= op_b.fract;
            small_fract <= op_a.fract;
          end else begin
            big_exp     <= op_a.exp;
            big_fract   <= op_a.fract;
            small_fract <= op_b.fract;
          end
          d         <= cmp_diff;
          shift_cnt <= '0;
`ifdef FP8_ADD_SEQ_ROUND_EN
          guard     <= 1'b0;
          sticky    <= 1'b0;
`endif
        end
        S_ALIGN: begin
          small_fract <= small_fract >> 1;
          d           <= d - EXP_W'(1);
          shift_cnt   <= shift_cnt + CNT_W'(1);
`ifdef FP8_ADD_SEQ_ROUND_EN
          if (align_capped && (d != EXP_W'(1))) begin
            // The shift cap is reached but shifts are still owed. Every
            // remaining bit lies below the guard position, so all of them
            // fold into sticky.
            guard  <= 1'b0;
            sticky <= sticky | guard | small_fract[0];
          end else begin
            guard  <= small_fract[0];
            sticky <= sticky | guard;
          end
`endif
        end
        S_ADD: acc <= sum_w;
        S_NORM: begin
          if (acc[FRAC_W]) begin
            if (big_exp == EXP_MAX) begin
              acc   <= {1'b0, {FRAC_W{1'b1}}};
              ovf_q <= 1'b1;
            end else begin
              acc     <= acc >> 1;
              big_exp <= big_exp + EXP_W'(1);
            end
          end else begin
            acc     <= acc << 1;
            big_exp <= big_exp - EXP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign exp_res   = big_exp;
  assign fract_res = acc[FRAC_W-1:0];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fp8_add_seq.sv
// ---------------------------------------------------------------------------
// tb_fp8_add_seq
//   Directed vectors with hand-computed results for fp8_add_seq.
//   The stimulus process pushes the expected result into a scoreboard queue.
//   A monitor process pops an entry on each output handshake and checks the
//   result and the latency.
// ---------------------------------------------------------------------------
module tb_fp8_add_seq;

  logic       clk, rst_n;
  logic       in_valid, in_ready;
  logic [2:0] exp_a, exp_b, exp_res;
  logic [3:0] fract_a, fract_b, fract_res;
  logic       out_valid, out_ready, ovf, busy;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0] ea; logic [3:0] fa;
    logic [2:0] eb; logic [3:0] fb;
    logic [2:0] er; logic [3:0] fr; logic ov;
    int lat; bit hold;
  } vec_t;

  typedef struct {
    logic [2:0] e; logic [3:0] f; logic o;
    int lat; int acc_cyc; int id;
  } exp_t;

  exp_t sb[$];

  fp8_add_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .exp_a     (exp_a),
    .fract_a   (fract_a),
    .exp_b     (exp_b),
    .fract_b   (fract_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .exp_res   (exp_res),
    .fract_res (fract_res),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    bit   prev_v;
    int   rise_cyc;
    exp_t e;
    prev_v   = 1'b0;
    rise_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid && !prev_v) rise_cyc = cyc;
        prev_v = out_valid;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            timeout("sb_unexpected_output");
          end else begin
            e = sb.pop_front();
            check($sformatf("v%0d_exp", e.id), exp_res, e.e);
            check($sformatf("v%0d_fract", e.id), fract_res, e.f);
            check($sformatf("v%0d_ovf", e.id), ovf, e.o);
            check($sformatf("v%0d_latency", e.id), rise_cyc - e.acc_cyc, e.lat);
          end
        end
      end
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v, input int id);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin tick(); t++; end
    if (!in_ready) begin timeout($sformatf("v%0d_idle_wait", id)); return; end
    in_valid = 1'b1;
    exp_a = v.ea; fract_a = v.fa; exp_b = v.eb; fract_b = v.fb;
    sb.push_back('{e: v.er, f: v.fr, o: v.ov, lat: v.lat, acc_cyc: cyc + 1, id: id});
    tick();
    // in_valid stays high with junk data while busy. The DUT must ignore it.
    exp_a = 3'd7; fract_a = 4'hF; exp_b = 3'd7; fract_b = 4'hF;
    if (v.hold) out_ready = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin tick(); t++; end
    in_valid = 1'b0;
    if (!out_valid) begin
      timeout($sformatf("v%0d_out_wait", id));
      out_ready = 1'b1;
      return;
    end
    if (v.hold) begin
      for (int i = 0; i < 5; i++) begin
        check("hold_out_valid", out_valid, 1);
        check("hold_exp", exp_res, v.er);
        check("hold_fract", fract_res, v.fr);
        check("hold_ovf", ovf, v.ov);
        check("hold_in_ready", in_ready, 0);
        tick();
      end
      out_ready = 1'b1;
    end
    tick();
    if (v.hold) begin
      check("post_hs_in_ready", in_ready, 1);
      check("post_hs_out_valid", out_valid, 0);
    end
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{3'd3, 4'b1000, 3'd1, 4'b1000, 3'd3, 4'b1010, 1'b0, 4, 0}; // align 2
    vecs[1] = '{3'd2, 4'b1100, 3'd2, 4'b1100, 3'd3, 4'b1100, 1'b0, 3, 0}; // carry
    vecs[2] = '{3'd7, 4'b1111, 3'd7, 4'b1000, 3'd7, 4'b1111, 1'b1, 3, 0}; // saturate
    vecs[3] = '{3'd0, 4'b0000, 3'd5, 4'b1010, 3'd5, 4'b1010, 1'b0, 6, 0}; // swap, cap 4
    vecs[4] = '{3'd3, 4'b0010, 3'd0, 4'b0000, 3'd1, 4'b1000, 1'b0, 7, 0}; // left norm 2
    vecs[5] = '{3'd2, 4'b0000, 3'd2, 4'b0000, 3'd2, 4'b0000, 1'b0, 2, 0}; // zero
    vecs[6] = '{3'd4, 4'b1001, 3'd4, 4'b1010, 3'd5, 4'b1001, 1'b0, 3, 0}; // fract swap
    vecs[7] = '{3'd1, 4'b1000, 3'd5, 4'b1100, 3'd5, 4'b1100, 1'b0, 6, 0}; // d=4 exact
    vecs[8] = '{3'd6, 4'b1100, 3'd4, 4'b1000, 3'd6, 4'b1110, 1'b0, 4, 1}; // hold

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    exp_a = '0; fract_a = '0; exp_b = '0; fract_b = '0;
    repeat (2) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_exp_res", exp_res, 0);
    check("rst_fract_res", fract_res, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) send(vecs[i], i);

    // Abort an operation in ALIGN with an asynchronous reset pulse.
    in_valid = 1'b1;
    exp_a = 3'd6; fract_a = 4'b1000; exp_b = 3'd1; fract_b = 4'b1000;
    tick();               // accepted, now in CMP
    in_valid = 1'b0;
    tick();               // now in ALIGN
    check("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_exp_res", exp_res, 0);
    check("abort_fract_res", fract_res, 0);
    check("abort_ovf", ovf, 0);
    check("abort_busy", busy, 0);
    #2 rst_n = 1'b1;
    tick();
    send(vecs[0], 100);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
